// File: rtl/single_port_sram_arbiter.sv
// single_port_sram_arbiter
// Two valid/ready clients sharing one single_port_sram. At most one SRAM
// command is issued per cycle. Read data comes back to the issuing port two
// cycles after the accept.
// Build option: define SRAM_ARB_FIXED_PRIORITY_EN to give port 0 fixed
// priority on ties. The default build uses round-robin.
module single_port_sram_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [WIDTH-1:0]      p0_wdata,
    output logic                  p0_rvalid,
    output logic [WIDTH-1:0]      p0_rdata,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [WIDTH-1:0]      p1_wdata,
    output logic                  p1_rvalid,
    output logic [WIDTH-1:0]      p1_rdata,
    output logic [ADDR_WIDTH-1:0] sram_address,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic                  sram_oe,
    inout  wire  [WIDTH-1:0]      sram_data
);

    logic                  cs_q, cs_d, we_q, we_d, oe_q, oe_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  rd_acc_q, rd_acc_d;
    logic [1:0]            pipe_v_q, pipe_v_d;
    logic [1:0]            pipe_id_q, pipe_id_d;

    logic elig0, elig1, cand0, cand1, pref1;
    logic acc0, acc1, acc_any, req_we;

    // A write directly after an accepted read would collide with the SRAM
    // driving read data, so writes wait one cycle after a read accept.
    assign elig0 = ~(p0_we & rd_acc_q);
    assign elig1 = ~(p1_we & rd_acc_q);
    assign cand0 = p0_valid & elig0;
    assign cand1 = p1_valid & elig1;

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
    assign pref1 = 1'b0;
`else
    logic last_q, last_d;
    // last_q holds the most recently granted port; the other one wins a tie.
    assign pref1 = ~last_q;

    // Round-robin pointer moves only when something is accepted.
    always_comb begin
        last_d = acc_any ? acc1 : last_q;
    end

    // Round-robin pointer register; port 0 wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
`endif

    assign p0_ready = ~rst & elig0 & ~(cand1 & pref1);
    assign p1_ready = ~rst & elig1 & ~(cand0 & ~pref1);
    assign acc0     = p0_valid & p0_ready;
    assign acc1     = p1_valid & p1_ready;
    assign acc_any  = acc0 | acc1;

    // Next SRAM command and read-tracking state from the accepted request.
    always_comb begin
        req_we  = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (acc1) begin
            req_we  = p1_we;
            addr_d  = p1_addr;
            wdata_d = p1_wdata;
        end else if (acc0) begin
            req_we  = p0_we;
            addr_d  = p0_addr;
            wdata_d = p0_wdata;
        end
        cs_d      = acc_any;
        we_d      = acc_any & req_we;
        oe_d      = acc_any & ~req_we;
        rd_acc_d  = oe_d;
        pipe_v_d  = {pipe_v_q[0], oe_d};
        pipe_id_d = {pipe_id_q[0], acc1};
    end

    // Command register, turnaround flag and read-in-flight shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            oe_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_acc_q  <= 1'b0;
            pipe_v_q  <= '0;
            pipe_id_q <= '0;
        end else begin
            cs_q      <= cs_d;
            we_q      <= we_d;
            oe_q      <= oe_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_acc_q  <= rd_acc_d;
            pipe_v_q  <= pipe_v_d;
            pipe_id_q <= pipe_id_d;
        end
    end

    assign sram_cs      = cs_q;
    assign sram_we      = we_q;
    assign sram_oe      = oe_q;
    assign sram_address = addr_q;
    assign sram_data    = (cs_q & we_q) ? wdata_q : {WIDTH{1'bz}};

    // Per-port response registers: capture the bus when the read that
    // reaches the end of the pipeline belongs to this port.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_resp
        logic             rv_q;
        logic [WIDTH-1:0] rd_q;
        logic             hit;
        assign hit = pipe_v_q[1] & (pipe_id_q[1] == 1'(gi));

        // Response capture; rdata holds between pulses.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rv_q <= 1'b0;
                rd_q <= '0;
            end else begin
                rv_q <= hit;
                if (hit) rd_q <= sram_data;
            end
        end
    end

    assign p0_rvalid = gen_resp[0].rv_q;
    assign p0_rdata  = gen_resp[0].rd_q;
    assign p1_rvalid = gen_resp[1].rv_q;
    assign p1_rdata  = gen_resp[1].rd_q;

endmodule
